vga_sync_gen: RTL and testbench

- Pixel-timing generator sitting directly upstream of the parallax renderer.
- Produces the horizontal/vertical counters, sync pulses and blanking qualifiers that the renderer consumes to compute `rgb` and drives straight to the `hsync`/`vsync` pads.
- One instance per chip, clocked from `wb_clk_i`, with a pixel-enable input so it runs at a divided pixel rate.

---
 rtl/vga_sync_gen.sv | 109 ++++++++++
 tb/tb_vga_sync_gen.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// Purpose : VGA pixel-timing generator: h/v counters, sync pulses, blanking/start qualifiers.
// Latency : every output is a register; decoded flags describe the hpos/vpos shown in the same cycle.
// Backpr. : none; pix_en gates the whole state, and all outputs hold while it is low.
//
// Ports:
//   clk         system/pixel clock
//   reset       asynchronous active-low reset; parks the counters on the last pixel of a frame
//   pix_en      pixel-rate enable; state advances only on edges where it is 1
//   hpos/vpos   current column (0..H_TOTAL-1) / line (0..V_TOTAL-1)
//   hsync/vsync sync pulses, active level SYNC_POL
//   display_on  visible-area qualifier
//   line_start  high while hpos==0
//   frame_start high while hpos==0 and vpos==0
//   vblank      high while vpos>=V_DISPLAY
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int HW        = 10,
    parameter int VW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS   = HW'(H_DISPLAY);
    localparam logic [VW-1:0] V_VIS   = VW'(V_DISPLAY);
    localparam logic [HW-1:0] HS_LO   = HW'(HS_START);
    localparam logic [HW-1:0] HS_HI   = HW'(HS_END);
    localparam logic [VW-1:0] VS_LO   = VW'(VS_START);
    localparam logic [VW-1:0] VS_HI   = VW'(VS_END);

    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          hsync_nxt;
    logic          vsync_nxt;
    logic          display_on_nxt;
    logic          line_start_nxt;
    logic          frame_start_nxt;
    logic          vblank_nxt;

    // Decode from the next counter values so the registered flags line up
    // with the registered counters without a cycle of lag.
    always_comb begin
        h_nxt = hpos + HW'(1);
        v_nxt = vpos;
        if (hpos == H_LAST) begin
            h_nxt = '0;
            v_nxt = (vpos == V_LAST) ? '0 : vpos + VW'(1);
        end

        hsync_nxt       = (h_nxt >= HS_LO && h_nxt <= HS_HI) ? SYNC_POL : ~SYNC_POL;
        // v_nxt only moves at the line wrap, so vsync is inherently line-aligned.
        vsync_nxt       = (v_nxt >= VS_LO && v_nxt <= VS_HI) ? SYNC_POL : ~SYNC_POL;
        display_on_nxt  = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        line_start_nxt  = (h_nxt == '0);
        frame_start_nxt = (h_nxt == '0) && (v_nxt == '0);
        vblank_nxt      = (v_nxt >= V_VIS);
    end

    // Reset values match the decode of (H_TOTAL-1, V_TOTAL-1), so the first
    // enabled edge after release is an ordinary wrap into (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b1;
        end else if (pix_en) begin
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            display_on  <= display_on_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
            vblank      <= vblank_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: one default-timing instance plus two shrunken-timing
// instances (active-low and active-high sync) sharing clock, reset and pix_en.
// A spec-level model pushes expected outputs per driven cycle; they are popped
// and compared at the following falling edge.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic       vb;
    } obs_t;

    typedef struct {
        bit rn;
        bit en;
        int h;
        int v;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
        bit vb;
    } vec_t;

    // Per-instance timing: index 0 default, 1 small active-low, 2 small active-high.
    int HD[3]  = '{640, 16, 16};
    int HF[3]  = '{16, 2, 2};
    int HSW[3] = '{96, 3, 3};
    int HB[3]  = '{48, 4, 4};
    int VD[3]  = '{480, 8, 8};
    int VF[3]  = '{10, 2, 2};
    int VSW[3] = '{2, 2, 2};
    int VB[3]  = '{33, 3, 3};
    bit POL[3] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pix_en = 1'b0;

    logic [9:0] h0, h1, h2, v0, v1, v2;
    logic hs0, hs1, hs2, vs0, vs1, vs2, de0, de1, de2;
    logic ls0, ls1, ls2, fs0, fs1, fs2, vb0, vb1, vb2;
    obs_t o0, o1, o2;

    assign o0 = {h0, v0, hs0, vs0, de0, ls0, fs0, vb0};
    assign o1 = {h1, v1, hs1, vs1, de1, ls1, fs1, vb1};
    assign o2 = {h2, v2, hs2, vs2, de2, ls2, fs2, vb2};

    always #5 clk = ~clk;

    vga_sync_gen u_d0 (
        .clk(clk), .reset(reset_n), .pix_en(pix_en),
        .hpos(h0), .vpos(v0), .hsync(hs0), .vsync(vs0), .display_on(de0),
        .line_start(ls0), .frame_start(fs0), .vblank(vb0)
    );

    vga_sync_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
        .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b0), .HW(10), .VW(10)
    ) u_d1 (
        .clk(clk), .reset(reset_n), .pix_en(pix_en),
        .hpos(h1), .vpos(v1), .hsync(hs1), .vsync(vs1), .display_on(de1),
        .line_start(ls1), .frame_start(fs1), .vblank(vb1)
    );

    vga_sync_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
        .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b1), .HW(10), .VW(10)
    ) u_d2 (
        .clk(clk), .reset(reset_n), .pix_en(pix_en),
        .hpos(h2), .vpos(v2), .hsync(hs2), .vsync(vs2), .display_on(de2),
        .line_start(ls2), .frame_start(fs2), .vblank(vb2)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   mh[3];
    int   mv[3];
    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];

    function automatic int ht(int d);
        return HD[d] + HF[d] + HSW[d] + HB[d];
    endfunction

    function automatic int vt(int d);
        return VD[d] + VF[d] + VSW[d] + VB[d];
    endfunction

    function automatic obs_t exp_of(int d, int h, int v);
        obs_t e;
        int hs_lo = HD[d] + HF[d];
        int hs_hi = hs_lo + HSW[d] - 1;
        int vs_lo = VD[d] + VF[d];
        int vs_hi = vs_lo + VSW[d] - 1;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = (h >= hs_lo && h <= hs_hi) ? POL[d] : !POL[d];
        e.vs = (v >= vs_lo && v <= vs_hi) ? POL[d] : !POL[d];
        e.de = (h < HD[d]) && (v < VD[d]);
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        e.vb = (v >= VD[d]);
        return e;
    endfunction

    function automatic obs_t rst_exp(int d);
        obs_t e;
        e.h  = 10'(ht(d) - 1);
        e.v  = 10'(vt(d) - 1);
        e.hs = !POL[d];
        e.vs = !POL[d];
        e.de = 1'b0;
        e.ls = 1'b0;
        e.fs = 1'b0;
        e.vb = 1'b1;
        return e;
    endfunction

    function automatic void cmp(string name, obs_t got, obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b vb=%b want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b vb=%b",
                     name, cyc, got.h, got.v, got.hs, got.vs, got.de, got.ls, got.fs, got.vb,
                     want.h, want.v, want.hs, want.vs, want.de, want.ls, want.fs, want.vb);
        end
    endfunction

    function automatic void chk_int(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endfunction

    // Drive one cycle's inputs, advance the model, queue the expected result.
    task automatic drive(input bit rn, input bit en);
        obs_t e[3];
        reset_n = rn;
        pix_en  = en;
        for (int d = 0; d < 3; d++) begin
            if (!rn) begin
                mh[d] = ht(d) - 1;
                mv[d] = vt(d) - 1;
                e[d]  = rst_exp(d);
            end else begin
                if (en) begin
                    if (mh[d] == ht(d) - 1) begin
                        mh[d] = 0;
                        mv[d] = (mv[d] == vt(d) - 1) ? 0 : mv[d] + 1;
                    end else begin
                        mh[d] = mh[d] + 1;
                    end
                end
                e[d] = exp_of(d, mh[d], mv[d]);
            end
        end
        q0.push_back(e[0]);
        q1.push_back(e[1]);
        q2.push_back(e[2]);
    endtask

    // Let the rising edge happen, then pop and compare at the falling edge.
    task automatic tick();
        obs_t e;
        @(negedge clk);
        cyc++;
        if (q0.size() > 0) begin e = q0.pop_front(); cmp("sb_d0", o0, e); end
        if (q1.size() > 0) begin e = q1.pop_front(); cmp("sb_d1", o1, e); end
        if (q2.size() > 0) begin e = q2.pop_front(); cmp("sb_d2", o2, e); end
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        obs_t w;
        int hs_cnt, hs_first, hs_last, de_cnt, ls_cnt, vs_cnt, vb_cnt, vs2_cnt, edge_bad;
        int fs_pos[$];
        logic prev_vs;

        // rn en  h    v   hs vs de ls fs vb
        tbl[0] = '{0, 1, 799, 524, 1, 1, 0, 0, 0, 1};
        tbl[1] = '{1, 1,   0,   0, 1, 1, 1, 1, 1, 0};
        tbl[2] = '{1, 0,   0,   0, 1, 1, 1, 1, 1, 0};
        tbl[3] = '{1, 1,   1,   0, 1, 1, 1, 0, 0, 0};
        tbl[4] = '{1, 1,   2,   0, 1, 1, 1, 0, 0, 0};
        tbl[5] = '{1, 0,   2,   0, 1, 1, 1, 0, 0, 0};
        tbl[6] = '{0, 1, 799, 524, 1, 1, 0, 0, 0, 1};
        tbl[7] = '{1, 0, 799, 524, 1, 1, 0, 0, 0, 1};
        tbl[8] = '{1, 1,   0,   0, 1, 1, 1, 1, 1, 0};

        for (int d = 0; d < 3; d++) begin
            mh[d] = ht(d) - 1;
            mv[d] = vt(d) - 1;
        end
        @(negedge clk);
        #1;

        // Reset state before any edge is released.
        cmp("reset_d0", o0, rst_exp(0));
        cmp("reset_d2", o2, rst_exp(2));

        // Table-driven first cycles on the default-timing instance.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].rn, tbl[i].en);
            tick();
            w = {10'(tbl[i].h), 10'(tbl[i].v), tbl[i].hs, tbl[i].vs,
                 tbl[i].de, tbl[i].ls, tbl[i].fs, tbl[i].vb};
            cmp($sformatf("tbl%0d", i), o0, w);
        end

        // Full rate: two default lines, five small frames.
        drive(0, 1);
        tick();
        hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0; ls_cnt = 0;
        vs_cnt = 0; vb_cnt = 0; vs2_cnt = 0; edge_bad = 0; prev_vs = 1'b1;
        for (int i = 0; i < 1605; i++) begin
            drive(1, 1);
            tick();
            if (i < 800) begin
                if (o0.hs == 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(o0.h);
                    hs_last = int'(o0.h);
                end
                if (o0.de) de_cnt++;
                if (o0.ls) ls_cnt++;
            end
            if (i < 375) begin
                if (o1.vs == 1'b0) vs_cnt++;
                if (o1.vb) vb_cnt++;
                if (o2.vs == 1'b1) vs2_cnt++;
            end
            if (i > 0 && o1.vs != prev_vs && o1.h != 10'd0) edge_bad++;
            prev_vs = o1.vs;
            if (o1.fs) fs_pos.push_back(i);
        end
        chk_int("hsync_low_cycles", hs_cnt, 96);
        chk_int("hsync_first_h", hs_first, 656);
        chk_int("hsync_last_h", hs_last, 751);
        chk_int("display_on_line0", de_cnt, 640);
        chk_int("line_start_line0", ls_cnt, 1);
        chk_int("vsync_low_small", vs_cnt, 50);
        chk_int("vsync_high_pol1", vs2_cnt, 50);
        chk_int("vblank_cycles_small", vb_cnt, 175);
        chk_int("vsync_edge_off_wrap", edge_bad, 0);
        chk_int("fs_count_full", fs_pos.size(), 5);
        if (fs_pos.size() >= 2) begin
            chk_int("fs_first_full", fs_pos[0], 0);
            chk_int("fs_period_full", fs_pos[1], 375);
        end

        // Half rate: frame_start must persist two clocks, frame spans 750 clocks.
        fs_pos.delete();
        drive(0, 0);
        tick();
        for (int i = 0; i < 1504; i++) begin
            drive(1, (i % 2) == 0);
            tick();
            if (o1.fs) fs_pos.push_back(i);
        end
        chk_int("fs_count_half", fs_pos.size(), 6);
        if (fs_pos.size() >= 3) begin
            chk_int("fs_half_0", fs_pos[0], 0);
            chk_int("fs_half_1", fs_pos[1], 1);
            chk_int("fs_half_2", fs_pos[2], 750);
        end

        // Arbitrary pix_en: the scoreboard catches any skipped or repeated value.
        for (int i = 0; i < 1000; i++) begin
            drive(1, 1'($urandom_range(0, 1)));
            tick();
        end

        // Mid-line reset on the default instance once it reaches hpos=300.
        for (int i = 0; i < 800 && mh[0] != 300; i++) begin
            drive(1, 1);
            tick();
        end
        chk_int("reach_h300", int'(o0.h), 300);
        drive(0, 1);
        #1;
        cmp("async_rst_d0", o0, rst_exp(0));
        cmp("async_rst_d1", o1, rst_exp(1));
        cmp("async_rst_d2", o2, rst_exp(2));
        tick();
        drive(0, 1);
        tick();
        drive(0, 0);
        tick();
        drive(1, 0);
        tick();
        drive(1, 1);
        tick();
        cmp("post_rst_origin", o0, exp_of(0, 0, 0));
        chk_int("post_rst_fs", int'(o0.fs), 1);

        drive(1, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
